// File: rtl/rf_multiport_sb.sv
// Two-write / two-read register file with debug read port, pending-write scoreboard and RAM-friendly init sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module rf_multiport_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [ADDR_W-1:0] reg_sel,
  output logic [DATA_W-1:0] reg_data
);

  localparam int   NUM_REGS = 2 ** ADDR_W;
  localparam logic Z0       = (ZERO_R0 != 0);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic                ready_r;
  logic [DATA_W-1:0]   mem_r [NUM_REGS];
  logic [NUM_REGS-1:0] sb_r;
  logic [NUM_REGS-1:0] sb_nxt_s;
  logic                run_s;
  logic                we0_ok_s;
  logic                we1_ok_s;

  assign run_s = (state_r == RUN);
  assign ready = ready_r;

  // True when addr is the hardwired-zero entry.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return Z0 && (addr == {ADDR_W{1'b0}});
  endfunction

  // Qualify write ports: port 1 wins a same-address collision, entry 0 may be read-only.
  always_comb begin
    we0_ok_s = 1'b0;
    we1_ok_s = 1'b0;
    if (run_s) begin
      we1_ok_s = we1 && !is_zero_addr(wa1);
      we0_ok_s = we0 && !is_zero_addr(wa0) && !(we1 && (wa1 == wa0));
    end else begin
      we0_ok_s = 1'b0;
      we1_ok_s = 1'b0;
    end
  end

  // Init sequencer: walks cnt through every entry once, then hands over to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= INIT;
      cnt_r   <= {ADDR_W{1'b0}};
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          if (cnt_r == {ADDR_W{1'b1}}) begin
            state_r <= RUN;
            ready_r <= 1'b1;
            cnt_r   <= {ADDR_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + ADDR_W'(1);
          end
        end
        RUN: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= INIT;
          cnt_r   <= {ADDR_W{1'b0}};
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset so it can map onto RAM; the sequencer clears it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run_s) begin
        mem_r[cnt_r] <= {DATA_W{1'b0}};
      end else begin
        if (we0_ok_s) mem_r[wa0] <= wd0;
        if (we1_ok_s) mem_r[wa1] <= wd1;
      end
    end
  end

  // Scoreboard next state: writes clear, sb_set applied last so it wins.
  always_comb begin
    sb_nxt_s = sb_r;
    if (run_s) begin
      if (we0) sb_nxt_s[wa0] = 1'b0;
      if (we1) sb_nxt_s[wa1] = 1'b0;
      if (sb_set) sb_nxt_s[sb_addr] = 1'b1;
    end else begin
      sb_nxt_s = sb_r;
    end
    if (Z0) begin
      sb_nxt_s[0] = 1'b0;
    end else begin
      sb_nxt_s[0] = sb_nxt_s[0];
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_r <= {NUM_REGS{1'b0}};
    end else begin
      sb_r <= sb_nxt_s;
    end
  end

  // Operand read with optional forwarding of the same-cycle write.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = mem_r[ra];
`ifdef RF_BYPASS_EN
    if (we1_ok_s && (wa1 == ra)) begin
      v = wd1;
    end else if (we0_ok_s && (wa0 == ra)) begin
      v = wd0;
    end else begin
      v = mem_r[ra];
    end
`endif
    return v;
  endfunction

  // Read ports are held at zero until the array has been cleared.
  always_comb begin
    rd1      = {DATA_W{1'b0}};
    rd2      = {DATA_W{1'b0}};
    reg_data = {DATA_W{1'b0}};
    busy1    = 1'b0;
    busy2    = 1'b0;
    if (run_s) begin
      rd1      = is_zero_addr(ra1)     ? {DATA_W{1'b0}} : read_port(ra1);
      rd2      = is_zero_addr(ra2)     ? {DATA_W{1'b0}} : read_port(ra2);
      reg_data = is_zero_addr(reg_sel) ? {DATA_W{1'b0}} : mem_r[reg_sel];
      busy1    = sb_r[ra1];
      busy2    = sb_r[ra2];
    end else begin
      rd1      = {DATA_W{1'b0}};
      rd2      = {DATA_W{1'b0}};
    end
  end

endmodule
